bcd_seg7_scan: RTL and testbench

Time-multiplexed 4-digit 7-segment driver that consumes the 17-bit packed BCD word produced by the binary-to-BCD converter and scans it onto a common-anode display. A load strobe captures each new value into a pending buffer. That buffer transfers to the display register only at a frame boundary, so a value never changes mid-frame. The block sits directly downstream of the converter, between the datapath and the board's anode/cathode pins.

---
 rtl/bcd_seg7_scan_if.sv | 19 +
 rtl/bcd_seg7_scan.sv | 122 ++++++++++++
 tb/tb_bcd_seg7_scan.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seg7_scan_if.sv
// rtl/bcd_seg7_scan_if.sv - packed-BCD input and anode/cathode pin bundle for bcd_seg7_scan
interface bcd_seg7_scan_if;
  logic [16:0] bcd_in;
  logic        load;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output bcd_in, load, blank,
    input  an, seg, dp
  );

  modport slave (
    input  bcd_in, load, blank,
    output an, seg, dp
  );
endinterface

// File: rtl/bcd_seg7_scan.sv
// rtl/bcd_seg7_scan.sv - 4-digit common-anode 7-segment scanner with frame-aligned display update
// Optional leading-zero blanking: define SEG7_LZB_EN.
module bcd_seg7_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_seg7_scan_if.slave bus
);

  typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} state_e;

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [16:0]   pend_q, pend_d;
  logic [16:0]   disp_q, disp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tc;
  logic [3:0]    nib;
  logic [3:0]    an_sel;
  logic          dig_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

`ifdef SEG7_LZB_EN
  logic lz3, lz2, lz1;
  // Blanking ripples down from the most significant digit; digit 0 always shows.
  assign lz3 = (disp_q[15:12] == 4'd0) && !disp_q[16];
  assign lz2 = lz3 && (disp_q[11:8] == 4'd0);
  assign lz1 = lz2 && (disp_q[7:4] == 4'd0);
`endif

  always_comb begin
    tc        = (cnt_q == CNT_MAX);
    cnt_d     = tc ? '0 : cnt_q + 1'b1;
    state_d   = state_q;
    pend_d    = bus.load ? bus.bcd_in : pend_q;
    disp_d    = disp_q;
    nib       = disp_q[3:0];
    an_sel    = 4'b1110;
    dig_blank = 1'b0;

    if (tc) begin
      case (state_q)
        SCAN0:   state_d = SCAN1;
        SCAN1:   state_d = SCAN2;
        SCAN2:   state_d = SCAN3;
        default: state_d = SCAN0;
      endcase
    end

    // Frame boundary: a value captured on this same edge waits one more frame.
    if (tc && state_q == SCAN3) begin
      disp_d = pend_q;
    end

    case (state_q)
      SCAN0: begin nib = disp_q[3:0];   an_sel = 4'b1110; end
      SCAN1: begin nib = disp_q[7:4];   an_sel = 4'b1101; end
      SCAN2: begin nib = disp_q[11:8];  an_sel = 4'b1011; end
      default: begin nib = disp_q[15:12]; an_sel = 4'b0111; end
    endcase

`ifdef SEG7_LZB_EN
    case (state_q)
      SCAN1:   dig_blank = lz1;
      SCAN2:   dig_blank = lz2;
      SCAN3:   dig_blank = lz3;
      default: dig_blank = 1'b0;
    endcase
`endif

    an_d  = bus.blank ? 4'b1111 : an_sel;
    seg_d = dig_blank ? 7'b1111111 : decode(nib);
    dp_d  = !((state_q == SCAN3) && disp_q[16]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= SCAN0;
      pend_q  <= '0;
      disp_q  <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb/tb_bcd_seg7_scan.sv - randomized self-checking bench for bcd_seg7_scan (REFRESH_DIV=4)
module tb_bcd_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic clk;
  logic rst_n;

  bcd_seg7_scan_if bus ();

  bcd_seg7_scan #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: elapsed cycles since reset release plus the two data words.
  int          n;
  logic [16:0] m_pend;
  logic [16:0] m_disp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (d > 9) return 7'b0111111;
    return tbl[d];
  endfunction

  function automatic logic [6:0] digit_seg(input logic [16:0] v, input int k);
    int d;
    d = (v >> (4 * k)) & 15;
`ifdef SEG7_LZB_EN
    if (k > 0 && v[16] == 1'b0 && (v[15:0] >> (4 * k)) == 0) return 7'b1111111;
`endif
    return glyph(d);
  endfunction

  task automatic model_reset();
    n      = 0;
    m_pend = '0;
    m_disp = '0;
  endtask

  task automatic tick(input logic ld, input logic [16:0] v, input logic bl);
    int k;
    bus.load   = ld;
    bus.bcd_in = v;
    bus.blank  = bl;
    k       = (n % FRAME) / DIV;
    exp_an  = bl ? 4'b1111 : ~(4'b0001 << k);
    exp_seg = digit_seg(m_disp, k);
    exp_dp  = !(k == 3 && m_disp[16]);
    if (n % FRAME == FRAME - 1) m_disp = m_pend;
    if (ld) m_pend = v;
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load = 1'b0; bus.bcd_in = '0; bus.blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold got an=%b seg=%b dp=%b exp an=1111 seg=1111111 dp=1", bus.an, bus.seg, bus.dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, '0, 1'b0);
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000 || bus.dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge got an=%b seg=%b dp=%b exp an=1110 seg=1000000 dp=1", bus.an, bus.seg, bus.dp);
    end
  endtask

  task automatic test_reset_midframe();
    tick(1'b1, 17'h05678, 1'b0);
    for (int i = 0; i < 2 * FRAME + 2; i++) tick(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_async got an=%b seg=%b dp=%b exp an=1111 seg=1111111 dp=1", bus.an, bus.seg, bus.dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME + 2; i++) begin
      tick(1'b0, '0, 1'b0);
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        errors++;
        $display("FAIL reset_resume n=%0d got %b/%b/%b exp %b/%b/%b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_normal_scan();
    tick(1'b1, 17'h01234, 1'b0);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick(1'b0, '0, 1'b0);
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        errors++;
        $display("FAIL normal_scan n=%0d got %b/%b/%b exp %b/%b/%b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_lzb();
    tick(1'b1, 17'h00007, 1'b0);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick(1'b0, '0, 1'b0);
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        errors++;
        $display("FAIL lzb n=%0d got %b/%b/%b exp %b/%b/%b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_overflow();
    tick(1'b1, 17'h16383, 1'b0);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick(1'b0, '0, 1'b0);
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        errors++;
        $display("FAIL overflow n=%0d got %b/%b/%b exp %b/%b/%b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_load_order();
    while (n % FRAME != 2) tick(1'b0, '0, 1'b0);
    tick(1'b1, 17'h00005, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b1, 17'h00009, 1'b0);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick(1'b0, '0, 1'b0);
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        errors++;
        $display("FAIL last_load_wins n=%0d got %b/%b/%b exp %b/%b/%b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
    while (n % FRAME != FRAME - 1) tick(1'b0, '0, 1'b0);
    tick(1'b1, 17'h00001, 1'b0);
    for (int j = 1; j <= 2 * FRAME; j++) begin
      tick(1'b0, '0, 1'b0);
      if (exp_an == 4'b1110) begin
        checks++;
        if (j <= FRAME && bus.seg !== 7'b0010000) begin
          errors++;
          $display("FAIL boundary_load_old j=%0d got %b exp 0010000", j, bus.seg);
        end
        if (j > FRAME && bus.seg !== 7'b1111001) begin
          errors++;
          $display("FAIL boundary_load_new j=%0d got %b exp 1111001", j, bus.seg);
        end
      end
    end
  endtask

  task automatic test_invalid_blank();
    tick(1'b1, 17'h0000A, 1'b0);
    for (int i = 0; i < FRAME + 3; i++) begin
      tick(1'b0, '0, 1'b0);
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        errors++;
        $display("FAIL invalid_digit n=%0d got %b/%b/%b exp %b/%b/%b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, '0, 1'b1);
      checks++;
      if (bus.an !== 4'b1111) begin
        errors++;
        $display("FAIL blank_an n=%0d got %b exp 1111", n, bus.an);
      end
    end
    for (int i = 0; i < FRAME + 2; i++) begin
      tick(1'b0, '0, 1'b0);
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        errors++;
        $display("FAIL blank_resume n=%0d got %b/%b/%b exp %b/%b/%b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    logic        ld;
    logic        bl;
    logic [16:0] v;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 5) == 0);
      bl = ($urandom_range(0, 9) == 0);
      v  = 17'($urandom);
      if ($urandom_range(0, 3) == 0) v[15:8] = 8'h00;
      tick(ld, v, bl);
      checks++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        errors++;
        $display("FAIL random n=%0d got %b/%b/%b exp %b/%b/%b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_normal_scan();
    test_lzb();
    test_overflow();
    test_load_order();
    test_invalid_blank();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
